// File: rtl/truth_table_sweeper.sv
// Exhaustively drives the 3-input circuit under test, capturing Q for every
// input combination and comparing the resulting truth table with exp.
module truth_table_sweeper #(
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] exp,
   input  logic       Q,
   output logic       A,
   output logic       B,
   output logic       C,
   output logic       busy,
   output logic       done,
   // 'table' is a reserved word, so the captured truth table uses this name
   output logic [7:0] captured_table,
   output logic       pass
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   state_t     state;
   state_t     state_next;
   logic [2:0] idx;
   logic [7:0] hcnt;
   logic       hold_end;
   logic       sweep_last;

   assign hold_end   = (hcnt == HOLD_LAST);
   assign sweep_last = hold_end && (idx == 3'd7);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Stimulus comes only from registered state and idx, so start never
   // reaches A/B/C combinationally.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      {A, B, C}  = 3'b000;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            busy      = 1'b1;
            {A, B, C} = idx;
            if (sweep_last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx            <= 3'd0;
         hcnt           <= 8'd0;
         captured_table <= 8'h00;
         pass           <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  idx            <= 3'd0;
                  hcnt           <= 8'd0;
                  captured_table <= 8'h00;
                  pass           <= 1'b0;
               end
            end
            RUN: begin
               if (hold_end) begin
                  captured_table[idx] <= Q;
                  hcnt                <= 8'd0;
                  // The final capture leaves idx at 7; DONE takes over instead of a wrap.
                  if (idx != 3'd7) begin
                     idx <= idx + 3'd1;
                  end else begin
                     pass <= (exp == {Q, captured_table[6:0]});
                  end
               end else begin
                  hcnt <= hcnt + 8'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized scoreboard bench: a sweep-timeline model predicts every output each
// cycle, and completed sweeps are matched against queued expected results.
module tb_truth_table_sweeper;

   localparam int H = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] exp;
   logic       Q;
   logic       A, B, C;
   logic       busy, done, pass;
   logic [7:0] captured_table;

   logic       start1;
   logic [7:0] exp1;
   logic       Q1;
   logic       A1, B1, C1;
   logic       busy1, done1, pass1;
   logic [7:0] captured_table1;

   logic [7:0] circ;
   logic [7:0] exp_final;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int         due;
      logic [7:0] tbl;
      logic       pass;
   } sweep_t;

   sweep_t sb_q[$];

   int         cyc = 0;
   logic       m_run = 1'b0;
   logic       m_done = 1'b0;
   int         m_left = 0;
   logic [7:0] m_table = 8'h00;
   logic       m_pass = 1'b0;
   logic [7:0] cur_circ = 8'h00;

   always #5 clk = ~clk;

   // The circuits under test are behavioural: a lookup table and a 3-input XOR.
   assign Q  = circ[{A, B, C}];
   assign Q1 = A1 ^ B1 ^ C1;

   truth_table_sweeper #(.HOLD_CYCLES(H)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .exp(exp), .Q(Q),
      .A(A), .B(B), .C(C), .busy(busy), .done(done),
      .captured_table(captured_table), .pass(pass)
   );

   truth_table_sweeper #(.HOLD_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .exp(exp1), .Q(Q1),
      .A(A1), .B(B1), .C(C1), .busy(busy1), .done(done1),
      .captured_table(captured_table1), .pass(pass1)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // A sweep lasts 8*H edges after acceptance, then one DONE cycle, then IDLE.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst_n) begin
         m_run   <= 1'b0;
         m_done  <= 1'b0;
         m_left  <= 0;
         m_table <= 8'h00;
         m_pass  <= 1'b0;
         sb_q.delete();
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (m_run) begin
         if (m_left == 1) begin
            m_run   <= 1'b0;
            m_done  <= 1'b1;
            m_table <= cur_circ;
            m_pass  <= (exp == cur_circ);
         end
         m_left <= m_left - 1;
      end else if (start) begin
         m_run    <= 1'b1;
         m_left   <= 8 * H;
         m_table  <= 8'h00;
         m_pass   <= 1'b0;
         cur_circ <= circ;
         sb_q.push_back('{due: cyc + 1 + 8 * H, tbl: circ, pass: (exp_final == circ)});
      end
   end

   int         elapsed;
   logic [8:0] mask;
   sweep_t     got;

   always @(negedge clk) begin
      elapsed = 8 * H - m_left;
      mask    = (9'd1 << (elapsed / H)) - 9'd1;
      checkOutput("busy", 32'(busy), 32'(m_run));
      checkOutput("done", 32'(done), 32'(m_done));
      if (m_run) begin
         checkOutput("abc_run", 32'({A, B, C}), 32'(elapsed / H));
         checkOutput("table_partial", 32'(captured_table), 32'(cur_circ & mask[7:0]));
         checkOutput("pass_run", 32'(pass), 32'd0);
      end else begin
         checkOutput("abc_idle", 32'({A, B, C}), 32'd0);
         checkOutput("table_hold", 32'(captured_table), 32'(m_table));
         checkOutput("pass_hold", 32'(pass), 32'(m_pass));
      end
      if (done === 1'b1) begin
         if (sb_q.size() == 0) begin
            checkOutput("unexpected_done", 32'd1, 32'd0);
         end else begin
            got = sb_q.pop_front();
            checkOutput("sb_done_cycle", 32'(cyc), 32'(got.due));
            checkOutput("sb_table", 32'(captured_table), 32'(got.tbl));
            checkOutput("sb_pass", 32'(pass), 32'(got.pass));
         end
      end
   end

   task automatic waitDone();
      int n = 0;
      while (done !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (done !== 1'b1) begin
         checkOutput("done_timeout", 32'(n), 32'd0);
      end
   endtask

   // One sweep with start pulses during RUN and DONE and a scrambled exp mid-sweep.
   task automatic applyStimulus(input logic [7:0] c, input logic [7:0] e);
      @(negedge clk);
      circ      = c;
      exp       = e;
      exp_final = e;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      start = 1'b1;
      exp   = ~e;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      exp = e;
      waitDone();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitDrained();
      int n = 0;
      while ((sb_q.size() != 0 || m_run || m_done) && n < 80) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain_timeout", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      logic [7:0] c;
      logic [7:0] e;
      int         n;

      rst_n     = 1'b0;
      start     = 1'b0;
      exp       = 8'h00;
      exp_final = 8'h00;
      circ      = 8'h00;
      start1    = 1'b0;
      exp1      = 8'h00;
      repeat (3) @(negedge clk);
      checkOutput("reset_table", 32'(captured_table), 32'h00);
      checkOutput("reset_pass", 32'(pass), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;

      applyStimulus(8'hE8, 8'hE8);
      applyStimulus(8'hE8, 8'hE9);

      for (int i = 0; i < 6; i++) begin
         c = 8'($urandom);
         e = ($urandom_range(0, 1) == 1) ? c : 8'($urandom);
         applyStimulus(c, e);
      end

      // Abort a sweep with reset while {A,B,C} = 5.
      @(negedge clk);
      circ      = 8'($urandom);
      exp       = circ;
      exp_final = circ;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while ({A, B, C} !== 3'b101 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checkOutput("abc_reaches_5", 32'({A, B, C}), 32'd5);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("abort_abc", 32'({A, B, C}), 32'd0);
      checkOutput("abort_table", 32'(captured_table), 32'h00);
      repeat (3 * H * 8) @(negedge clk);
      applyStimulus(8'($urandom), 8'h5A);

      // Start held high: back-to-back sweeps with one IDLE cycle between them.
      @(negedge clk);
      circ      = 8'hFF;
      exp       = 8'hFF;
      exp_final = 8'hFF;
      start     = 1'b1;
      repeat (80) @(negedge clk);
      start = 1'b0;
      waitDrained();

      // HOLD_CYCLES = 1 instance sweeping a 3-input XOR.
      @(negedge clk);
      exp1   = 8'h96;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      n = 0;
      while (done1 !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("h1_done_edge", 32'(n), 32'd8);
      checkOutput("h1_table", 32'(captured_table1), 32'h96);
      checkOutput("h1_pass", 32'(pass1), 32'd1);
      checkOutput("h1_busy_in_done", 32'(busy1), 32'd0);
      @(negedge clk);
      checkOutput("h1_done_pulse", 32'(done1), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
